scan_arbiter: RTL and testbench

Round-robin scheduler that shares the single combinational item checker (the discounted/stolen UPC logic) between two checkout scanner lanes. It accepts one item code per grant, presents it to the checker, captures the checker's verdict, and reports it back tagged with the lane. It also keeps per-lane discount counters and sticky theft alarms. It sits between the lane scanners and the checker instance in the top level.

---
 rtl/scan_arbiter.sv | 153 +++++++++++++++
 tb/tb_scan_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_arbiter.sv
// rtl/scan_arbiter.sv - round-robin sharing of one item checker between two scanner lanes
module scan_arbiter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [2:0]       upc0,
    input  logic [2:0]       upc1,
    input  logic             mark0,
    input  logic             mark1,
    input  logic [1:0]       clr,
    output logic [1:0]       ack,
    output logic [2:0]       chk_upc,
    output logic             chk_mark,
    input  logic             chk_disc,
    input  logic             chk_stolen,
    output logic             res_valid,
    output logic             res_lane,
    output logic             res_disc,
    output logic             res_stolen,
    output logic [1:0]       alarm,
    output logic [CNT_W-1:0] disc_cnt0,
    output logic [CNT_W-1:0] disc_cnt1
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       state;
    logic             last_grant;
    logic             lane;
    logic             pick;
    logic [2:0]       code_upc;
    logic             code_mark;
    logic             cap_disc;
    logic             cap_stolen;
    logic             take;
    logic [1:0]       rep_hit;
    logic [1:0]       inc;
    logic [1:0]       set_alarm;
    logic [CNT_W-1:0] cnt [2];
    logic [CNT_W-1:0] cnt_nxt [2];

    // Winner selection: a lone requester wins, a tie goes to the lane not served last.
    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_grant;
            default: pick = 1'b0;
        endcase
    end

    // An item is accepted only from IDLE; requests seen in CHECK/REPORT simply wait.
    assign take = (state == IDLE) && (|req);

    // Three-phase sequencer: accept, let the checker settle, report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (|req) state <= CHECK;
                CHECK:   state <= REPORT;
                REPORT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Latch the winning lane and its code; the code register feeds the checker directly
    // so the checker inputs are glitch-free and hold their value outside CHECK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            lane       <= 1'b0;
            code_upc   <= 3'b000;
            code_mark  <= 1'b0;
        end else if (take) begin
            last_grant <= pick;
            lane       <= pick;
            code_upc   <= pick ? upc1 : upc0;
            code_mark  <= pick ? mark1 : mark0;
        end
    end

    // Capture the checker verdict at the end of the CHECK cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_disc   <= 1'b0;
            cap_stolen <= 1'b0;
        end else if (state == CHECK) begin
            cap_disc   <= chk_disc;
            cap_stolen <= chk_stolen;
        end
    end

    assign chk_upc  = code_upc;
    assign chk_mark = code_mark;

    // All handshake/result outputs decode from registers only, never from lane inputs.
    assign ack        = (state == CHECK) ? (lane ? 2'b10 : 2'b01) : 2'b00;
    assign res_valid  = (state == REPORT);
    assign res_lane   = res_valid & lane;
    assign res_disc   = res_valid & cap_disc;
    assign res_stolen = res_valid & cap_stolen;

    assign rep_hit   = res_valid ? (lane ? 2'b10 : 2'b01) : 2'b00;
    assign inc       = rep_hit & {2{cap_disc}};
    assign set_alarm = rep_hit & {2{cap_stolen}};

    // Next discount count per lane: clear beats hold, but a clear coinciding with an
    // increment leaves exactly the new item counted; increments saturate at all-ones.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            cnt_nxt[n] = cnt[n];
            if (clr[n]) begin
                cnt_nxt[n] = inc[n] ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
            end else if (inc[n] && (cnt[n] != CNT_MAX)) begin
                cnt_nxt[n] = cnt[n] + 1'b1;
            end
        end
    end

    // Per-lane discount counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            cnt[0] <= cnt_nxt[0];
            cnt[1] <= cnt_nxt[1];
        end
    end

    assign disc_cnt0 = cnt[0];
    assign disc_cnt1 = cnt[1];

    // Sticky theft alarms: a new theft report wins over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm <= 2'b00;
        end else begin
            alarm <= set_alarm | (alarm & ~clr);
        end
    end

endmodule

// File: tb/tb_scan_arbiter.sv
// tb/tb_scan_arbiter.sv - randomized self-checking bench for scan_arbiter
module tb_scan_arbiter;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [2:0]       upc0, upc1;
    logic             mark0, mark1;
    logic [1:0]       clr;
    logic [1:0]       ack;
    logic [2:0]       chk_upc;
    logic             chk_mark;
    logic             chk_disc, chk_stolen;
    logic             res_valid, res_lane, res_disc, res_stolen;
    logic [1:0]       alarm;
    logic [CNT_W-1:0] disc_cnt0, disc_cnt1;

    // bench-side item checker: lookup tables the stimulus can reprogram
    logic [7:0]  disc_tab;
    logic [15:0] stolen_tab;
    assign chk_disc   = disc_tab[chk_upc];
    assign chk_stolen = stolen_tab[{chk_upc, chk_mark}];

    scan_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req(req), .upc0(upc0), .upc1(upc1),
        .mark0(mark0), .mark1(mark1), .clr(clr), .ack(ack),
        .chk_upc(chk_upc), .chk_mark(chk_mark), .chk_disc(chk_disc),
        .chk_stolen(chk_stolen), .res_valid(res_valid), .res_lane(res_lane),
        .res_disc(res_disc), .res_stolen(res_stolen), .alarm(alarm),
        .disc_cnt0(disc_cnt0), .disc_cnt1(disc_cnt1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Transaction-level reference: an item granted at edge g is acked in the cycle after g,
    // reported in the cycle after g+1, and its bookkeeping lands at edge g+2.
    int e = 0;
    int g = -10;
    int w = 0;
    int last = 1;
    int next_free = 0;
    int cu = 0, cm = 0, vd = 0, vs = 0;
    int cnt [2];
    int alm [2];
    int grants [2];
    int glog [$];

    task automatic model_edge();
        e++;
        if (reset) begin
            g = -10; w = 0; last = 1; next_free = e + 1;
            cu = 0; cm = 0; vd = 0; vs = 0;
            for (int n = 0; n < 2; n++) begin cnt[n] = 0; alm[n] = 0; end
            return;
        end
        for (int n = 0; n < 2; n++) begin
            bit rep_here;
            rep_here = (e == g + 2) && (w == n);
            if (clr[n]) cnt[n] = (rep_here && vd != 0) ? 1 : 0;
            else if (rep_here && vd != 0 && cnt[n] < CNT_MAX) cnt[n] = cnt[n] + 1;
            if (rep_here && vs != 0) alm[n] = 1;
            else if (clr[n]) alm[n] = 0;
        end
        if (e == g + 1) begin
            vd = int'(disc_tab[cu]);
            vs = int'(stolen_tab[cu * 2 + cm]);
        end
        if (e >= next_free && req != 2'b00) begin
            if (req == 2'b11) w = 1 - last;
            else w = req[1] ? 1 : 0;
            last = w;
            cu = (w == 1) ? int'(upc1) : int'(upc0);
            cm = (w == 1) ? int'(mark1) : int'(mark0);
            g = e;
            next_free = e + 3;
            grants[w]++;
            glog.push_back(w);
        end
    endtask

    // stimulus state
    bit       pend [2];
    logic [2:0] pu [2];
    logic     pm [2];
    bit       src [2];
    int       rate = 100;
    int       clr_rate = 0;
    logic [1:0] clr_force = 2'b00;
    logic [1:0] clr_rep_mask = 2'b00;

    task automatic drive();
        logic [1:0] c;
        c = clr_force;
        if (e == g + 1) c = c | (clr_rep_mask & ((w == 1) ? 2'b10 : 2'b01));
        for (int n = 0; n < 2; n++)
            if ($urandom_range(99) < clr_rate) c[n] = 1'b1;
        clr   = c;
        req   = {pend[1], pend[0]};
        upc0  = pu[0];
        upc1  = pu[1];
        mark0 = pm[0];
        mark1 = pm[1];
    endtask

    task automatic step();
        logic [1:0] exp_ack;
        @(posedge clk);
        model_edge();
        #1;
        exp_ack = (e == g) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
        check_eq("ack", 32'(ack), 32'(exp_ack));
        check_eq("res_valid", 32'(res_valid), 32'(e == g + 1));
        if (e == g + 1) begin
            check_eq("res_lane", 32'(res_lane), 32'(w));
            check_eq("res_disc", 32'(res_disc), 32'(vd));
            check_eq("res_stolen", 32'(res_stolen), 32'(vs));
        end
        check_eq("chk_upc", 32'(chk_upc), 32'(cu));
        check_eq("chk_mark", 32'(chk_mark), 32'(cm));
        check_eq("alarm", 32'(alarm), 32'(alm[1] * 2 + alm[0]));
        check_eq("disc_cnt0", 32'(disc_cnt0), 32'(cnt[0]));
        check_eq("disc_cnt1", 32'(disc_cnt1), 32'(cnt[1]));
        for (int n = 0; n < 2; n++) begin
            if (e == g && w == n) pend[n] = 0;
            if (!pend[n] && src[n] && $urandom_range(99) < rate) begin
                pend[n] = 1;
                pu[n] = 3'($urandom);
                pm[n] = 1'($urandom);
            end
        end
        drive();
    endtask

    task automatic run(input int ncyc);
        repeat (ncyc) step();
    endtask

    initial begin
        int g0, bound;
        for (int n = 0; n < 2; n++) begin
            pend[n] = 0; pu[n] = 3'b000; pm[n] = 1'b0; src[n] = 0;
            cnt[n] = 0; alm[n] = 0; grants[n] = 0;
        end
        disc_tab = 8'h00; stolen_tab = 16'h0000;
        reset = 1'b1;
        drive();
        run(2);
        reset = 1'b0;
        run(1);

        // single lane, discounted item 101
        disc_tab = 8'b0010_0000;
        pend[0] = 1; pu[0] = 3'b101; pm[0] = 1'b0;
        drive();
        step();
        check_eq("single_ack", 32'(ack), 32'h1);
        check_eq("single_chk_upc", 32'(chk_upc), 32'h5);
        step();
        check_eq("single_res_valid", 32'(res_valid), 32'h1);
        check_eq("single_res_lane", 32'(res_lane), 32'h0);
        check_eq("single_res_disc", 32'(res_disc), 32'h1);
        step();
        check_eq("single_cnt0", 32'(disc_cnt0), 32'h1);
        run(2);

        // asynchronous reset in the middle of CHECK
        pend[0] = 1; pu[0] = 3'b011; pm[0] = 1'b1;
        drive();
        step();
        check_eq("rst_pre_ack", 32'(ack), 32'h1);
        pend[0] = 1;
        drive();
        reset = 1'b1;
        #1;
        check_eq("rst_async_ack", 32'(ack), 32'h0);
        check_eq("rst_async_rv", 32'(res_valid), 32'h0);
        check_eq("rst_async_chk", 32'({chk_upc, chk_mark}), 32'h0);
        check_eq("rst_async_cnt", 32'({disc_cnt1, disc_cnt0}), 32'h0);
        check_eq("rst_async_alarm", 32'(alarm), 32'h0);
        step();
        pend[0] = 0;
        reset = 1'b0;
        drive();
        repeat (4) begin
            step();
            check_eq("rst_no_rv", 32'(res_valid), 32'h0);
        end

        // fairness: both lanes requesting continuously
        glog.delete();
        disc_tab = 8'($urandom);
        src[0] = 1; src[1] = 1; rate = 100;
        pend[0] = 1; pend[1] = 1; pu[0] = 3'($urandom); pu[1] = 3'($urandom);
        drive();
        run(12);
        check_eq("fair_count", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++)
            check_eq("fair_order", 32'(glog[i]), 32'(i % 2));
        src[0] = 0; src[1] = 0;
        run(8);

        // theft alarm
        stolen_tab = 16'hFFFF;
        pend[1] = 1; pu[1] = 3'($urandom); pm[1] = 1'($urandom);
        drive();
        run(4);
        check_eq("theft_set", 32'(alarm), 32'h2);
        stolen_tab = 16'h0000;
        src[1] = 1;
        run(9);
        src[1] = 0;
        run(6);
        check_eq("theft_sticky", 32'(alarm), 32'h2);
        clr_force = 2'b10;
        drive();
        step();
        clr_force = 2'b00;
        drive();
        check_eq("theft_clr", 32'(alarm), 32'h0);
        stolen_tab = 16'hFFFF;
        clr_rep_mask = 2'b10;
        pend[1] = 1; pu[1] = 3'($urandom);
        drive();
        run(3);
        check_eq("theft_set_wins", 32'(alarm), 32'h2);
        clr_rep_mask = 2'b00;
        stolen_tab = 16'h0000;
        drive();
        run(2);

        // saturation of lane 0 counter
        clr_force = 2'b01;
        drive();
        step();
        clr_force = 2'b00;
        disc_tab = 8'hFF;
        src[0] = 1;
        pend[0] = 1; pu[0] = 3'($urandom);
        drive();
        g0 = grants[0];
        bound = 0;
        while (grants[0] - g0 < 17 && bound < 200) begin
            step();
            bound++;
        end
        check_eq("sat_items", 32'(grants[0] - g0), 32'd17);
        src[0] = 0; pend[0] = 0;
        drive();
        run(3);
        check_eq("sat_cnt0", 32'(disc_cnt0), 32'd15);
        clr_rep_mask = 2'b01;
        pend[0] = 1;
        drive();
        run(3);
        check_eq("sat_clr_inc", 32'(disc_cnt0), 32'd1);
        clr_rep_mask = 2'b00;
        drive();
        run(2);

        // idle hold
        repeat (10) begin
            step();
            check_eq("idle_ack", 32'(ack), 32'h0);
            check_eq("idle_rv", 32'(res_valid), 32'h0);
        end

        // randomized traffic
        src[0] = 1; src[1] = 1; rate = 40; clr_rate = 5;
        for (int blk = 0; blk < 60; blk++) begin
            disc_tab = 8'($urandom);
            stolen_tab = 16'($urandom);
            run(25);
        end
        src[0] = 0; src[1] = 0; clr_rate = 0;
        run(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
